conv_frame_loader: RTL and testbench



---
 rtl/conv_frame_loader_if.sv | 27 ++
 rtl/conv_frame_loader.sv | 170 +++++++++++++++++
 tb/tb_conv_frame_loader.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_frame_loader_if.sv
// rtl/conv_frame_loader_if.sv - pixel stream and convolution-core launch signals of the frame loader
interface conv_frame_loader_if #(
  parameter int DW   = 8,
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int N = ROWS * COLS;

  logic                 s_valid;
  logic signed [DW-1:0] s_data;
  logic                 s_last;
  logic                 s_ready;
  logic [N*DW-1:0]      frame_data;
  logic                 conv_start;
  logic                 conv_done;
  logic                 conv_busy;

  modport master (
    output s_valid, s_data, s_last, conv_done,
    input  s_ready, frame_data, conv_start, conv_busy
  );

  modport slave (
    input  s_valid, s_data, s_last, conv_done,
    output s_ready, frame_data, conv_start, conv_busy
  );
endinterface

// File: rtl/conv_frame_loader.sv
// rtl/conv_frame_loader.sv - ping-pong frame assembler feeding the 8x8 convolution core
module conv_frame_loader #(
  parameter int DW   = 8,
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic               clk,
  input  logic               reset,
  conv_frame_loader_if.slave bus,
  output logic               err_short,
  output logic               err_long,
  output logic [15:0]        frame_cnt
);
  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

  typedef enum logic {FILL, DROP} fill_state_e;
  typedef enum logic {IDLE, RUN}  launch_state_e;

  fill_state_e   fill_state_q, fill_state_d;
  launch_state_e launch_state_q, launch_state_d;

  logic [DW-1:0] bank_q [2][N];
  logic [DW-1:0] bank_d [2][N];
  logic [1:0]    bank_full_q, bank_full_d;
  logic          fill_sel_q, fill_sel_d;
  logic          launch_sel_q, launch_sel_d;
  logic          pres_sel_q, pres_sel_d;
  logic          shown_q, shown_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          err_short_q, err_short_d;
  logic          err_long_q, err_long_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic [1:0]      occupied;
  logic [1:0]      full_set;
  logic [1:0]      full_clr;
  logic            s_ready;
  logic            beat;
  logic            conv_start;
  logic            disp_sel;
  logic [N*DW-1:0] frame_flat;

  // A bank is unavailable to the filler while it waits to launch or is being convolved.
  always_comb begin
    occupied = bank_full_q;
    if (launch_state_q == RUN) occupied[pres_sel_q] = 1'b1;
  end

  assign s_ready = (fill_state_q == DROP) || !occupied[fill_sel_q];
  assign beat    = bus.s_valid && s_ready;

  always_comb begin
    fill_state_d = fill_state_q;
    fill_sel_d   = fill_sel_q;
    wr_ptr_d     = wr_ptr_q;
    bank_d       = bank_q;
    err_short_d  = 1'b0;
    err_long_d   = 1'b0;
    full_set     = 2'b00;
    case (fill_state_q)
      FILL: begin
        if (beat) begin
          bank_d[fill_sel_q][wr_ptr_q] = bus.s_data;
          if (wr_ptr_q == LAST_IDX) begin
            full_set[fill_sel_q] = 1'b1;
            fill_sel_d           = ~fill_sel_q;
            wr_ptr_d             = '0;
            if (!bus.s_last) begin
              err_long_d   = 1'b1;
              fill_state_d = DROP;
            end
          end else if (bus.s_last) begin
            err_short_d = 1'b1;
            wr_ptr_d    = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
        end
      end
      DROP: begin
        if (beat && bus.s_last) fill_state_d = FILL;
      end
      default: fill_state_d = FILL;
    endcase
  end

  // Banks launch in alternation, which matches the alternating fill order.
  always_comb begin
    launch_state_d = launch_state_q;
    launch_sel_d   = launch_sel_q;
    pres_sel_d     = pres_sel_q;
    shown_d        = shown_q;
    frame_cnt_d    = frame_cnt_q;
    conv_start     = 1'b0;
    full_clr       = 2'b00;
    case (launch_state_q)
      IDLE: begin
        if (bank_full_q[launch_sel_q]) begin
          conv_start             = 1'b1;
          full_clr[launch_sel_q] = 1'b1;
          pres_sel_d             = launch_sel_q;
          launch_sel_d           = ~launch_sel_q;
          shown_d                = 1'b1;
          frame_cnt_d            = frame_cnt_q + 16'd1;
          launch_state_d         = RUN;
        end
      end
      RUN: begin
        if (bus.conv_done) launch_state_d = IDLE;
      end
      default: launch_state_d = IDLE;
    endcase
  end

  assign bank_full_d = (bank_full_q & ~full_clr) | full_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_state_q   <= FILL;
      launch_state_q <= IDLE;
      bank_full_q    <= 2'b00;
      fill_sel_q     <= 1'b0;
      launch_sel_q   <= 1'b0;
      pres_sel_q     <= 1'b0;
      shown_q        <= 1'b0;
      wr_ptr_q       <= '0;
      err_short_q    <= 1'b0;
      err_long_q     <= 1'b0;
      frame_cnt_q    <= 16'd0;
    end else begin
      fill_state_q   <= fill_state_d;
      launch_state_q <= launch_state_d;
      bank_full_q    <= bank_full_d;
      fill_sel_q     <= fill_sel_d;
      launch_sel_q   <= launch_sel_d;
      pres_sel_q     <= pres_sel_d;
      shown_q        <= shown_d;
      wr_ptr_q       <= wr_ptr_d;
      err_short_q    <= err_short_d;
      err_long_q     <= err_long_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  // Pixel storage carries no reset; emptiness is tracked by bank_full_q and the launch state.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  assign disp_sel = conv_start ? launch_sel_q : pres_sel_q;

  always_comb begin
    frame_flat = '0;
    if (shown_q || conv_start) begin
      for (int i = 0; i < N; i++) begin
        frame_flat[i*DW +: DW] = bank_q[disp_sel][i];
      end
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.conv_start = conv_start;
  assign bus.conv_busy  = (launch_state_q == RUN);
  assign bus.frame_data = frame_flat;
  assign err_short      = err_short_q;
  assign err_long       = err_long_q;
  assign frame_cnt      = frame_cnt_q;
endmodule

// File: tb/tb_conv_frame_loader.sv
// tb/tb_conv_frame_loader.sv - scoreboard bench for the ping-pong frame loader
module tb_conv_frame_loader;
  localparam int DW = 8;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int N = ROWS * COLS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        err_short;
  logic        err_long;
  logic [15:0] frame_cnt;

  conv_frame_loader_if #(.DW(DW), .ROWS(ROWS), .COLS(COLS)) bus ();

  conv_frame_loader #(.DW(DW), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .err_short (err_short),
    .err_long  (err_long),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: accepted beats accumulate until a frame completes, errors are predicted by rule.
  logic [N*DW-1:0] exp_frames[$];
  logic [DW-1:0]   cur[$];
  int              exp_err[$];
  bit              dropping = 0;
  int              exp_cnt = 0;
  bit              start_prev = 0;
  bit              cnt_chk = 0;
  int              start_cyc = -1;
  int              beat_cyc = -1;
  bit              auto_done = 0;
  int              done_delay = 5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_frame(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input logic last);
    logic [N*DW-1:0] f;
    if (dropping) begin
      if (last) dropping = 0;
      return;
    end
    cur.push_back(d);
    if (cur.size() == N) begin
      for (int i = 0; i < N; i++) f[i*DW +: DW] = cur[i];
      exp_frames.push_back(f);
      cur.delete();
      if (!last) begin
        exp_err.push_back(2);
        dropping = 1;
      end
    end else if (last) begin
      exp_err.push_back(1);
      cur.delete();
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit done_in_reset);
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.conv_done = done_in_reset;
    step(1);
    bus.conv_done = 1'b0;
    step(1);
    exp_frames.delete();
    cur.delete();
    exp_err.delete();
    dropping = 0;
    exp_cnt = 0;
    start_prev = 0;
    cnt_chk = 0;
    reset = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last, input int gap_pct, output int stalls);
    int acc_cyc;
    stalls = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      bus.s_valid = 1'b0;
      step(1);
    end
    bus.s_valid = 1'b1;
    bus.s_data = d;
    bus.s_last = last;
    while (1) begin
      @(negedge clk);
      acc_cyc = cyc;
      if (bus.s_ready) break;
      stalls++;
      if (stalls > 3000) begin
        miscompares++;
        vectors++;
        $display("FAIL beat_timeout: s_ready stayed 0 for %0d cycles, required 1", stalls);
        bus.s_valid = 1'b0;
        step(1);
        return;
      end
    end
    step(1);
    model_beat(d, last);
    beat_cyc = acc_cyc;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
  endtask

  task automatic pulse_done();
    bus.conv_done = 1'b1;
    step(1);
    bus.conv_done = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (n < 5000 && (exp_frames.size() != 0 || bus.conv_busy || bus.conv_start)) begin
      step(1);
      n++;
    end
    check("drain_done", {31'b0, n < 5000}, 1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT launches a frame or flags an error.
  initial begin
    int kind;
    logic [N*DW-1:0] f;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (cnt_chk) begin
        check("launch_cnt", {16'b0, frame_cnt}, exp_cnt);
        check("launch_busy", {31'b0, bus.conv_busy}, 1);
        cnt_chk = 0;
      end
      if (bus.conv_start) begin
        start_cyc = cyc;
        check("start_width", {31'b0, start_prev}, 0);
        if (exp_frames.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_start: conv_start=1 with no frame pending, required 0");
        end else begin
          f = exp_frames.pop_front();
          check_frame("frame_data", bus.frame_data, f);
          exp_cnt = (exp_cnt + 1) % 65536;
          cnt_chk = 1;
        end
      end
      start_prev = bus.conv_start;
      if (err_short || err_long) begin
        kind = (err_short ? 1 : 0) + (err_long ? 2 : 0);
        if (exp_err.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_err: err kind %0d, required none", kind);
        end else begin
          check("err_kind", kind, exp_err.pop_front());
        end
      end
    end
  end

  initial begin
    bus.conv_done = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_done && bus.conv_busy && !reset) begin
        repeat (done_delay) @(posedge clk);
        #1;
        bus.conv_done = 1'b1;
        @(posedge clk);
        #1;
        bus.conv_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

  initial begin
    int st;
    int tot;
    logic [N*DW-1:0] pat;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;

    // Reset state
    do_reset(0);
    @(negedge clk);
    check("rst_s_ready", {31'b0, bus.s_ready}, 1);
    check("rst_busy", {31'b0, bus.conv_busy}, 0);
    check("rst_start", {31'b0, bus.conv_start}, 0);
    check("rst_cnt", {16'b0, frame_cnt}, 0);
    check("rst_errs", {30'b0, err_short, err_long}, 0);
    check_frame("rst_frame", bus.frame_data, '0);
    step(1);

    // Basic ramp frame
    start_cyc = -1;
    for (int k = 0; k < N; k++) send_beat(8'(k - 32), k == N - 1, 0, st);
    step(2);
    check("start_latency", start_cyc - beat_cyc, 1);
    @(negedge clk);
    check("basic_busy", {31'b0, bus.conv_busy}, 1);
    check("basic_cnt", {16'b0, frame_cnt}, 1);
    step(1);
    pulse_done();
    step(2);

    // Ping-pong with conv_done withheld
    for (int k = 0; k < N; k++) send_beat(8'h11, k == N - 1, 0, st);
    tot = 0;
    for (int k = 0; k < N; k++) begin
      send_beat(8'h7F, k == N - 1, 0, st);
      tot += st;
    end
    check("b_stalls", tot, 0);
    bus.s_valid = 1'b1;
    bus.s_data = 8'h01;
    @(negedge clk);
    check("c_ready_low", {31'b0, bus.s_ready}, 0);
    pat = {N{8'h11}};
    check_frame("a_held", bus.frame_data, pat);
    step(1);
    fork
      begin
        step(4);
        pulse_done();
      end
    join_none
    for (int k = 0; k < N; k++) begin
      send_beat(8'($urandom_range(255)), k == N - 1, 0, st);
      if (k == 0) check("c_first_stalled", {31'b0, st > 0}, 1);
    end
    step(6);
    auto_done = 1;
    done_delay = 5;
    wait_drain();
    check("pp_err_pending", exp_err.size(), 0);

    // Short frame then full frame
    auto_done = 0;
    do_reset(0);
    for (int k = 0; k <= 10; k++) send_beat(8'($urandom_range(255)), k == 10, 0, st);
    step(4);
    check("short_no_launch", {31'b0, bus.conv_busy}, 0);
    check("short_err_seen", exp_err.size(), 0);
    auto_done = 1;
    for (int k = 0; k < N; k++) send_beat(8'(k - 128), k == N - 1, 0, st);
    wait_drain();
    check("short_cnt", {16'b0, frame_cnt}, 1);

    // Long frame: 70 beats, last on 69
    tot = 0;
    for (int k = 0; k < 70; k++) begin
      send_beat(8'($urandom_range(255)), k == 69, 0, st);
      if (k >= N) tot += st;
    end
    check("drop_stalls", tot, 0);
    for (int k = 0; k < N; k++) send_beat(8'($urandom_range(255)), k == N - 1, 0, st);
    wait_drain();
    check("long_cnt", {16'b0, frame_cnt}, 3);
    check("long_err_pending", exp_err.size(), 0);

    // Random valid with 20-cycle core latency
    do_reset(0);
    done_delay = 20;
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < N; k++) send_beat(8'($urandom_range(255)), k == N - 1, 50, st);
    wait_drain();
    check("rand_cnt", {16'b0, frame_cnt}, 4);

    // Reset mid-operation
    auto_done = 0;
    do_reset(0);
    for (int k = 0; k < N; k++) send_beat(8'($urandom_range(255)), k == N - 1, 0, st);
    for (int k = 0; k < 30; k++) send_beat(8'($urandom_range(255)), 1'b0, 0, st);
    do_reset(1);
    @(negedge clk);
    check("mid_s_ready", {31'b0, bus.s_ready}, 1);
    check("mid_busy", {31'b0, bus.conv_busy}, 0);
    check("mid_cnt", {16'b0, frame_cnt}, 0);
    check("mid_start", {31'b0, bus.conv_start}, 0);
    step(2);
    pulse_done();
    @(negedge clk);
    check("mid_done_ignored", {31'b0, bus.conv_busy}, 0);
    step(1);
    auto_done = 1;
    done_delay = 5;
    for (int k = 0; k < N; k++) send_beat(8'($urandom_range(255)), k == N - 1, 0, st);
    wait_drain();
    check("mid_fresh_cnt", {16'b0, frame_cnt}, 1);
    check("final_err_pending", exp_err.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
